// File: rtl/hilo_mdu.sv
// Iterative multiply/divide unit owning the HI/LO registers (shift-add multiply, restoring divide).
// Optional macro MDU_EARLY_OUT_EN ends a multiply as soon as the remaining multiplier bits are zero.
module hilo_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StartE,
  input  logic [1:0]       MDOpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             HiWeE,
  input  logic             LoWeE,
  input  logic [WIDTH-1:0] WDataE,
  output logic             BusyE,
  output logic             DoneE,
  output logic [WIDTH-1:0] HiE,
  output logic [WIDTH-1:0] LoE
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_prod, r_mcand;
  logic [WIDTH-1:0]   r_mpl, r_rem, r_quo, r_dvsr, r_rawA, r_hi, r_lo;
  logic               r_negRes, r_negRem, r_isDiv, r_dz, r_done;

  logic               w_signed, w_aNeg, w_bNeg, w_lastIter;
  logic [WIDTH-1:0]   w_magA, w_magB, w_mplNext, w_quoFix, w_remFix, w_hiFix, w_loFix;
  logic [WIDTH:0]     w_remSh, w_diff;
  logic [2*WIDTH-1:0] w_prodFix;

  // Operands are captured as magnitudes; the signs are reapplied once in FIX.
  assign w_signed   = ~MDOpE[0];
  assign w_aNeg     = w_signed & SrcAE[WIDTH-1];
  assign w_bNeg     = w_signed & SrcBE[WIDTH-1];
  assign w_magA     = w_aNeg ? -SrcAE : SrcAE;
  assign w_magB     = w_bNeg ? -SrcBE : SrcBE;
  assign w_mplNext  = r_mpl >> 1;
  assign w_lastIter = (r_cnt == CW'(WIDTH - 1));
  assign w_remSh    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_remSh - {1'b0, r_dvsr};
  assign w_prodFix  = r_negRes ? -r_prod : r_prod;
  assign w_quoFix   = r_negRes ? -r_quo : r_quo;
  assign w_remFix   = r_negRem ? -r_rem : r_rem;
  assign w_hiFix    = r_dz ? r_rawA : (r_isDiv ? w_remFix : w_prodFix[2*WIDTH-1:WIDTH]);
  assign w_loFix    = r_dz ? '1 : (r_isDiv ? w_quoFix : w_prodFix[WIDTH-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (StartE) w_next = MDOpE[1] ? ((SrcBE == '0) ? FIX : DIV) : MUL;
`ifdef MDU_EARLY_OUT_EN
      MUL:  if (w_lastIter || (w_mplNext == '0)) w_next = FIX;
`else
      MUL:  if (w_lastIter) w_next = FIX;
`endif
      DIV:  if (w_lastIter) w_next = FIX;
      FIX:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    BusyE = (r_state != IDLE);
    DoneE = r_done;
    HiE   = r_hi;
    LoE   = r_lo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mpl    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_rawA   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_negRes <= 1'b0;
      r_negRem <= 1'b0;
      r_isDiv  <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == FIX);
      unique case (r_state)
        IDLE: begin
          if (StartE) begin
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, w_magA};
            r_mpl    <= w_magB;
            r_rem    <= '0;
            r_quo    <= w_magA;
            r_dvsr   <= w_magB;
            r_rawA   <= SrcAE;
            r_negRes <= w_aNeg ^ w_bNeg;
            r_negRem <= w_aNeg;
            r_isDiv  <= MDOpE[1];
            r_dz     <= MDOpE[1] && (SrcBE == '0);
          end else begin
            if (HiWeE) r_hi <= WDataE;
            if (LoWeE) r_lo <= WDataE;
          end
        end
        MUL: begin
          r_cnt   <= r_cnt + 1'b1;
          r_prod  <= r_mpl[0] ? (r_prod + r_mcand) : r_prod;
          r_mcand <= r_mcand << 1;
          r_mpl   <= w_mplNext;
        end
        DIV: begin
          r_cnt <= r_cnt + 1'b1;
          // A clear borrow bit means the divisor fits: keep the difference and emit a 1.
          if (!w_diff[WIDTH]) begin
            r_rem <= w_diff[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_remSh[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          r_hi <= w_hiFix;
          r_lo <= w_loFix;
        end
        default: ;
      endcase
    end
  end

endmodule
